// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared ALU control codes and MDU state encoding.
// Used by hilo_mdu and anything that drives its alucontrol input.
package hilo_mdu_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'h18;
  localparam logic [4:0] MULTU_CONTROL = 5'h19;
  localparam logic [4:0] DIV_CONTROL   = 5'h1a;
  localparam logic [4:0] DIVU_CONTROL  = 5'h1b;
  localparam logic [4:0] MFHI_CONTROL  = 5'h10;
  localparam logic [4:0] MFLO_CONTROL  = 5'h12;
  localparam logic [4:0] MTHI_CONTROL  = 5'h11;
  localparam logic [4:0] MTLO_CONTROL  = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// div_iter: radix-2 restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst      clock, async active-low reset
//   load          capture a/b/signed_en and start WIDTH iterations
//   signed_en     treat a and b as two's complement
//   a, b          dividend, divisor
//   busy          iterations outstanding
//   done          high during the final iteration cycle
//   quot, rem     sign-corrected results, valid once busy drops
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q starts as |a| and is shifted out while quotient bits shift in.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   r_sh, diff;

  always_comb begin
    a_neg  = signed_en & a[WIDTH-1];
    b_neg  = signed_en & b[WIDTH-1];
    r_sh   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff   = r_sh - {1'b0, dvs_q};
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (load) begin
      cnt_d  = CNT_W'(WIDTH);
      dvd_d  = a_neg ? -a : a;
      dvs_d  = b_neg ? -b : b;
      rem_d  = '0;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = (b == '0);
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (!diff[WIDTH]) begin
        rem_d = diff;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = r_sh;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  // With a zero divisor the remainder already equals |a|; restoring the sign
  // of a gives back a itself, so only the quotient needs forcing.
  assign quot = dz_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
  assign rem  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: execute-stage multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst        clock, async active-low reset
//   start           MDU instruction present in execute
//   alucontrol      *_CONTROL operation code
//   a, b            rs / rt operands
//   flush           abandon in-flight operation
//   stall           hold pipeline (combinational)
//   result          MFHI/MFLO read data, else 0
//   hi, lo          architectural HI/LO
//
// state | meaning
// IDLE  | accepting; MTHI/MTLO/MFHI/MFLO complete here
// MUL   | product moving through the register chain
// DIV   | divider iterating
// DONE  | result ready, HI/LO written at the end of this cycle
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int CTRL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CTRL_W-1:0] alucontrol,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              flush,
  output logic              stall,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             op_div_q, op_div_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [2*WIDTH-1:0] mul_pipe_q [MUL_LAT];
  logic [2*WIDTH-1:0] mul_pipe_d [MUL_LAT];

  logic is_mul, is_div, is_signed, accept;
  logic div_busy, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] xe, ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  always_comb begin
    is_mul    = (alucontrol == CTRL_W'(MULT_CONTROL)) | (alucontrol == CTRL_W'(MULTU_CONTROL));
    is_div    = (alucontrol == CTRL_W'(DIV_CONTROL))  | (alucontrol == CTRL_W'(DIVU_CONTROL));
    is_signed = (alucontrol == CTRL_W'(MULT_CONTROL)) | (alucontrol == CTRL_W'(DIV_CONTROL));
    accept    = (state_q == IDLE) & start & (is_mul | is_div) & ~flush;
    stall     = accept | (state_q == MUL) | (state_q == DIV);
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & is_div),
    .signed_en (is_signed),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // Stage 0 is loaded with the product on the acceptance edge, so the
  // acceptance cycle counts as the first multiply stall cycle. MUL holds
  // for the remaining MUL_LAT-1 cycles; with MUL_LAT=1 it is skipped.
  always_comb begin
    mul_pipe_d = mul_pipe_q;
    if (accept & is_mul) mul_pipe_d[0] = mul_full(a, b, is_signed);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe_d[i] = mul_pipe_q[i-1];
  end

  always_comb begin
    state_d   = state_q;
    op_div_d  = op_div_q;
    mul_cnt_d = mul_cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_div_d  = is_div;
          mul_cnt_d = CNT_W'(MUL_LAT - 2);
          if (is_div)            state_d = DIV;
          else if (MUL_LAT == 1) state_d = DONE;
          else                   state_d = MUL;
        end else if (start & ~flush) begin
          if (alucontrol == CTRL_W'(MTHI_CONTROL)) hi_d = a;
          if (alucontrol == CTRL_W'(MTLO_CONTROL)) lo_d = a;
        end
      end
      MUL: begin
        if (mul_cnt_q == '0) state_d = DONE;
        else                 mul_cnt_d = mul_cnt_q - CNT_W'(1);
      end
      DIV: begin
        if (div_done | ~div_busy) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (op_div_q) begin
          hi_d = div_rem;
          lo_d = div_quot;
        end else begin
          {hi_d, lo_d} = mul_pipe_q[MUL_LAT-1];
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_comb begin
    result = '0;
    if (start & (alucontrol == CTRL_W'(MFHI_CONTROL))) result = hi_q;
    if (start & (alucontrol == CTRL_W'(MFLO_CONTROL))) result = lo_q;
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      op_div_q  <= 1'b0;
      mul_cnt_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      op_div_q   <= op_div_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_pipe_q <= mul_pipe_d;
    end
  end
endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Iterative multiply/divide unit with HI/LO registers; executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO as selected by the ALU control code.
- Sits in the execute stage beside the ALU.
- Stalls the pipeline while a multi-cycle operation runs, and supports flush on exception/branch.
- Parametrised in data width and multiplier latency.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- MUL_LAT, 2, multiply stall cycles (≥1); the product is taken through an internal MUL_LAT-stage register chain.
- CTRL_W, 5, width of the alucontrol code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  an MDU instruction is present in the execute stage; held high by the pipeline while stall=1.
- alucontrol  in  CTRL_W  operation code, using the shared *_CONTROL values.
- a  in  WIDTH  rs operand; dividend / multiplicand / MTHI-MTLO source.
- b  in  WIDTH  rt operand; divisor / multiplier.
- flush  in  1  kill the in-flight operation.
- stall  out  1  hold the pipeline (combinational).
- result  out  WIDTH  MFHI/MFLO read data; 0 for all other ops.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi, lo, counter and internal datapath = 0. Consequently stall=0 and result=0. Reset mid-operation abandons the operation.
- States:
  - IDLE -> MUL on start & MULT/MULTU.
  - IDLE -> DIV on start & DIV/DIVU.
  - MUL -> DONE after MUL_LAT cycles counted from entry.
  - DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on flush.
- Latching: operands and op are captured on the IDLE->busy edge. Inputs are ignored while busy.
- Stall: stall = (state==IDLE & start & op∈{MULT,MULTU,DIV,DIVU} & ~flush) | state∈{MUL,DIV}. stall=0 in DONE, so the instruction leaves execute on the DONE edge.
- Total stall cycles: MUL_LAT for multiply; WIDTH+1 for divide (one setup cycle in the IDLE acceptance cycle plus WIDTH iterations).
- Multiply: full 2·WIDTH product. MULT is signed, MULTU unsigned. {hi,lo} <= product on the DONE edge.
- Divide: radix-2 restoring, one quotient bit per cycle on absolute values.
  - Signed: quotient negated iff a[MSB]^b[MSB]; remainder takes the sign of a.
  - lo <= quotient, hi <= remainder on the DONE edge.
  - Most-negative ÷ -1 (signed): lo = most-negative value, hi = 0.
- Divide by zero (b=0): still takes the full WIDTH+1 cycles. lo = all ones; hi = a unmodified. Applies to both DIV and DIVU.
- MTHI/MTLO: hi/lo <= a at the edge of the start cycle (IDLE only). No stall. Ignored if flush is asserted in the same cycle.
- MFHI/MFLO: result = hi/lo combinationally in the same cycle. An MFHI issued in the cycle after DONE sees the new value.
- Flush:
  - Any state -> IDLE at the next edge; hi/lo unchanged.
  - Flush in the DONE cycle suppresses the HI/LO write.
  - Flush wins over start in the same cycle.
- Unknown alucontrol with start=1: no state change, no stall, result=0.

Decomposition:
- Shared defines header (the team's existing one) holds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO_CONTROL codes and the state encodings IDLE/MUL/DIV/DONE.
- One sub-module: div_iter. It is a WIDTH-parametrised restoring divider with ports clk, rst, load, signed_en, a, b, busy, done, quot, rem, and owns the iteration counter and sign fix-up.
- Multiply pipeline and HI/LO control stay in hilo_mdu.

Test Plan:
- MULT a=0x7FFFFFFF b=2 -> stall for 2 cycles; then hi=0x00000000, lo=0xFFFFFFFE. MFHI in the next cycle returns 0.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Also MULT a=0xFFFFFFFF b=1 -> hi=lo=0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9) b=2 -> 33 stall cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5, then DIV with flush at iteration 10 -> stall drops the cycle after flush; hi stays 0xA5A5A5A5. Repeat with rst=0 mid-DIV -> hi=lo=0 immediately, stall=0.
- WIDTH=16, MUL_LAT=1: MULT 0x8000×0x8000 -> hi=0x4000, lo=0x0000 after 1 stall cycle. DIV 100/7 -> 17 stall cycles, lo=14, hi=2.
